// File: rtl/rotor_return.sv
// rotor_return: return-path (reflector-to-keyboard) stage of one Enigma rotor.
// Maps an incoming letter index through the inverse rotor wiring at the
// current rotor position. It also owns the registered rotor position, with
// load, step and notch-carry logic, so several stages can be chained.
//
// Ports:
//   clock      system clock; every state change happens on the rising edge
//   reset      synchronous, active-high reset
//   set        load set_state into the position register
//   set_state  position to load, 0..25; values >= 26 load 0
//   step       single-cycle request to advance the position by one
//   in_valid   in_letter is valid this cycle
//   in_letter  return-path letter index, 0..25
//   out_valid  registered strobe qualifying out_letter/out_err
//   out_letter registered mapped letter index; holds while out_valid=0
//   out_err    registered flag: the accepted input index was >= 26
//   state      current rotor position
//   carry      registered one-cycle pulse when the rotor steps off NOTCH
module rotor_return #(
  parameter int NOTCH     = 16,
  parameter int RESET_POS = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       set,
  input  logic [4:0] set_state,
  input  logic       step,
  input  logic       in_valid,
  input  logic [4:0] in_letter,
  output logic       out_valid,
  output logic [4:0] out_letter,
  output logic       out_err,
  output logic [4:0] state,
  output logic       carry
);

  localparam logic [4:0] NOTCH_POS = 5'(NOTCH);
  localparam logic [4:0] RST_POS   = 5'(RESET_POS);

  // The wiring is a set of disjoint swaps, so it is its own inverse. The
  // return path therefore uses the same table as the forward path.
  function automatic logic [4:0] wire_map(input logic [4:0] x);
    logic [4:0] y;
    case (x)
      5'd0:  y = 5'd17;  5'd17: y = 5'd0;
      5'd1:  y = 5'd20;  5'd20: y = 5'd1;
      5'd2:  y = 5'd12;  5'd12: y = 5'd2;
      5'd3:  y = 5'd23;  5'd23: y = 5'd3;
      5'd4:  y = 5'd9;   5'd9:  y = 5'd4;
      5'd5:  y = 5'd10;  5'd10: y = 5'd5;
      5'd6:  y = 5'd15;  5'd15: y = 5'd6;
      5'd7:  y = 5'd18;  5'd18: y = 5'd7;
      5'd8:  y = 5'd25;  5'd25: y = 5'd8;
      5'd11: y = 5'd24;  5'd24: y = 5'd11;
      5'd13: y = 5'd16;  5'd16: y = 5'd13;
      5'd14: y = 5'd21;  5'd21: y = 5'd14;
      5'd19: y = 5'd22;  5'd22: y = 5'd19;
      default: y = 5'd0;
    endcase
    return y;
  endfunction

  logic [4:0] pos_q;
  logic [4:0] pos_next;
  logic       in_range;
  logic [5:0] in6;
  logic [5:0] pos6;
  logic [5:0] diff;
  logic [5:0] sum;
  logic [4:0] mapped;

  assign state    = pos_q;
  assign in_range = (in_letter < 5'd26);

  // (W((in - pos) mod 26) + pos) mod 26 with one conditional +/-26 fix-up
  // per stage. The subtraction wraps mod 64, and adding 26 then lands it
  // back in 0..25.
  always_comb begin
    in6    = {1'b0, in_letter};
    pos6   = {1'b0, pos_q};
    diff   = in6 - pos6;
    if (in6 < pos6) begin
      diff = diff + 6'd26;
    end
    sum    = {1'b0, wire_map(diff[4:0])} + pos6;
    if (sum >= 6'd26) begin
      sum = sum - 6'd26;
    end
    mapped = sum[4:0];
  end

  always_comb begin
    pos_next = pos_q;
    if (set) begin
      pos_next = (set_state < 5'd26) ? set_state : 5'd0;
    end else if (step) begin
      pos_next = (pos_q == 5'd25) ? 5'd0 : pos_q + 5'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pos_q      <= RST_POS;
      carry      <= 1'b0;
      out_valid  <= 1'b0;
      out_letter <= 5'd0;
      out_err    <= 1'b0;
    end else begin
      pos_q     <= pos_next;
      // A set overrides a simultaneous step, so that step never produces a carry.
      carry     <= step && !set && (pos_q == NOTCH_POS);
      out_valid <= in_valid;
      if (in_valid) begin
        out_letter <= in_range ? mapped : 5'd0;
        out_err    <= !in_range;
      end
    end
  end

endmodule

// File: tb/tb_rotor_return.sv
module tb_rotor_return;

  logic       clock = 1'b0;
  logic       reset;
  logic       set;
  logic [4:0] set_state;
  logic       step;
  logic       in_valid;
  logic [4:0] in_letter;
  logic       out_valid;
  logic [4:0] out_letter;
  logic       out_err;
  logic [4:0] state;
  logic       carry;

  int checks = 0;
  int errors = 0;

  rotor_return #(.NOTCH(16), .RESET_POS(0)) dut (
    .clock      (clock),
    .reset      (reset),
    .set        (set),
    .set_state  (set_state),
    .step       (step),
    .in_valid   (in_valid),
    .in_letter  (in_letter),
    .out_valid  (out_valid),
    .out_letter (out_letter),
    .out_err    (out_err),
    .state      (state),
    .carry      (carry)
  );

  always #5 clock = ~clock;

  // Reference wiring, written as a pair list and looked up both ways.
  function automatic int ref_w(input int x);
    int a [13] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 11, 13, 14, 19};
    int b [13] = '{17, 20, 12, 23, 9, 10, 15, 18, 25, 24, 16, 21, 22};
    for (int i = 0; i < 13; i++) begin
      if (a[i] == x) return b[i];
      if (b[i] == x) return a[i];
    end
    return -1;
  endfunction

  // Forward transform: W((L - s) mod 26) + s, mod 26.
  function automatic int ref_fwd(input int l, input int s);
    return (ref_w((l - s + 26) % 26) + s) % 26;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  initial begin
    reset = 1'b1; set = 1'b0; set_state = 5'd0; step = 1'b0;
    in_valid = 1'b0; in_letter = 5'd0;
    tick();
    tick();
    check("rst_state", int'(state), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_letter", int'(out_letter), 0);
    check("rst_out_err", int'(out_err), 0);
    check("rst_carry", int'(carry), 0);
    reset = 1'b0;

    // Basic mapping at position 0
    in_valid = 1'b1; in_letter = 5'd0;
    tick();
    check("map0_valid", int'(out_valid), 1);
    check("map0_letter", int'(out_letter), 17);
    in_letter = 5'd8;
    tick();
    check("map8_letter", int'(out_letter), 25);
    in_valid = 1'b0; in_letter = 5'd3;
    tick();
    check("idle_valid", int'(out_valid), 0);
    check("idle_hold", int'(out_letter), 25);

    // Rotated mapping
    set = 1'b1; set_state = 5'd1;
    tick();
    set = 1'b0;
    check("set1_state", int'(state), 1);
    in_valid = 1'b1; in_letter = 5'd0;
    tick();
    check("rot1_letter", int'(out_letter), 9);
    in_valid = 1'b0;
    set = 1'b1; set_state = 5'd25;
    tick();
    set = 1'b0;
    in_valid = 1'b1; in_letter = 5'd24;
    tick();
    check("rot25_letter", int'(out_letter), 7);
    check("rot25_err", int'(out_err), 0);
    in_valid = 1'b0;

    // Stepping through the notch
    set = 1'b1; set_state = 5'd15;
    tick();
    set = 1'b0; step = 1'b1;
    tick();
    check("step16_state", int'(state), 16);
    check("step16_carry", int'(carry), 0);
    tick();
    check("step17_state", int'(state), 17);
    check("step17_carry", int'(carry), 1);
    tick();
    check("step18_state", int'(state), 18);
    check("step18_carry", int'(carry), 0);
    step = 1'b0;
    set = 1'b1; set_state = 5'd25;
    tick();
    set = 1'b0; step = 1'b1;
    tick();
    step = 1'b0;
    check("wrap_state", int'(state), 0);
    check("wrap_carry", int'(carry), 0);

    // Set beats step, even at the notch, and gives no carry
    set = 1'b1; set_state = 5'd16;
    tick();
    set_state = 5'd5; step = 1'b1;
    tick();
    set = 1'b0; step = 1'b0;
    check("prio_state", int'(state), 5);
    check("prio_carry", int'(carry), 0);

    // Step with in_valid maps at the pre-step position
    set = 1'b1; set_state = 5'd0;
    tick();
    set = 1'b0; step = 1'b1; in_valid = 1'b1; in_letter = 5'd0;
    tick();
    step = 1'b0; in_valid = 1'b0;
    check("simul_letter", int'(out_letter), 17);
    check("simul_state", int'(state), 1);

    // Out-of-range input
    in_valid = 1'b1; in_letter = 5'd27;
    tick();
    check("oor_valid", int'(out_valid), 1);
    check("oor_err", int'(out_err), 1);
    check("oor_letter", int'(out_letter), 0);

    // Reset discards the in_valid of the same cycle
    in_letter = 5'd0; reset = 1'b1;
    tick();
    reset = 1'b0; in_valid = 1'b0;
    check("rstmid_valid", int'(out_valid), 0);
    check("rstmid_state", int'(state), 0);
    check("rstmid_err", int'(out_err), 0);

    // Out-of-range set_state loads 0
    set = 1'b1; set_state = 5'd3;
    tick();
    set_state = 5'd30;
    tick();
    set = 1'b0;
    check("set30_state", int'(state), 0);

    // Round trip over every position and letter
    for (int s = 0; s < 26; s++) begin
      set = 1'b1; set_state = 5'(s); in_valid = 1'b0;
      tick();
      set = 1'b0;
      for (int l = 0; l < 26; l++) begin
        in_valid = 1'b1; in_letter = 5'(l);
        tick();
        check($sformatf("rt_s%0d_l%0d", s, l),
              (out_valid && !out_err) ? ref_fwd(int'(out_letter), s) : -1, l);
      end
      in_valid = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
